// File: rtl/fifo_checker.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_checker
//  Purpose  : Cycle-accurate shadow model of the synchronous FIFO that compares
//             all eight FIFO outputs every cycle and keeps saturating stats.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  chk_en,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  err_pulse,
  output logic [7:0]            err_mask,
  output logic                  first_err_valid,
  output logic [7:0]            first_err_mask,
  output logic [CNT_WIDTH-1:0]  first_err_cycle
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH_M1 = c_CNT_W'(FIFO_DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [FIFO_WIDTH-1:0] r_exp_data_out;
  logic                  r_exp_wr_ack, r_exp_overflow, r_exp_underflow;

  logic [CNT_WIDTH-1:0]  r_correct_count, r_error_count, r_cycle_count;
  logic [CNT_WIDTH-1:0]  r_first_err_cycle;
  logic                  r_err_pulse, r_first_err_valid;
  logic [7:0]            r_err_mask, r_first_err_mask;

  logic       w_exp_full, w_exp_empty, w_exp_almostfull, w_exp_almostempty;
  logic       w_wr_acc, w_rd_acc, w_mismatch;
  logic [7:0] w_mask;

  assign w_exp_full        = (r_count == c_DEPTH);
  assign w_exp_empty       = (r_count == '0);
  assign w_exp_almostfull  = (r_count == c_DEPTH_M1);
  assign w_exp_almostempty = (r_count == c_ONE);
  assign w_wr_acc          = wr_en && (r_count < c_DEPTH);
  assign w_rd_acc          = rd_en && (r_count != '0);

  // Case inequality so that X/Z on an observed output is flagged as a mismatch.
  always_comb begin
    w_mask    = '0;
    w_mask[0] = (data_out    !== r_exp_data_out);
    w_mask[1] = (full        !== w_exp_full);
    w_mask[2] = (empty       !== w_exp_empty);
    w_mask[3] = (almostfull  !== w_exp_almostfull);
    w_mask[4] = (almostempty !== w_exp_almostempty);
    w_mask[5] = (wr_ack      !== r_exp_wr_ack);
    w_mask[6] = (overflow    !== r_exp_overflow);
    w_mask[7] = (underflow   !== r_exp_underflow);
  end

  assign w_mismatch = |w_mask;

  always_ff @(posedge clk) begin
    if (w_wr_acc && rst_n) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_exp_data_out  <= '0;
      r_exp_wr_ack    <= 1'b0;
      r_exp_overflow  <= 1'b0;
      r_exp_underflow <= 1'b0;
    end else begin
      r_exp_wr_ack    <= w_wr_acc;
      r_exp_overflow  <= wr_en && w_exp_full;
      r_exp_underflow <= rd_en && w_exp_empty;
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_exp_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr       <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_correct_count   <= '0;
      r_error_count     <= '0;
      r_cycle_count     <= '0;
      r_err_pulse       <= 1'b0;
      r_err_mask        <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_mask  <= '0;
      r_first_err_cycle <= '0;
    end else begin
      r_err_pulse <= chk_en && w_mismatch;
      if (chk_en) begin
        r_err_mask <= w_mask;
      end
      if (clr_stats) begin
        r_correct_count   <= '0;
        r_error_count     <= '0;
        r_cycle_count     <= '0;
        r_first_err_valid <= 1'b0;
        r_first_err_mask  <= '0;
        r_first_err_cycle <= '0;
      end else if (chk_en) begin
        // All counters saturate rather than wrap.
        if (!(&r_cycle_count)) r_cycle_count <= r_cycle_count + 1'b1;
        if (w_mismatch) begin
          if (!(&r_error_count)) r_error_count <= r_error_count + 1'b1;
          if (!r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_mask  <= w_mask;
            r_first_err_cycle <= r_cycle_count;
          end
        end else if (!(&r_correct_count)) begin
          r_correct_count <= r_correct_count + 1'b1;
        end
      end
    end
  end

  assign correct_count   = r_correct_count;
  assign error_count     = r_error_count;
  assign cycle_count     = r_cycle_count;
  assign err_pulse       = r_err_pulse;
  assign err_mask        = r_err_mask;
  assign first_err_valid = r_first_err_valid;
  assign first_err_mask  = r_first_err_mask;
  assign first_err_cycle = r_first_err_cycle;

endmodule
`default_nettype wire
